// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed restoring divider producing MIPS DIV hi/lo results
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             zero_div,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_quo_q, neg_quo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             zero_div_q, zero_div_d;

  logic             accept;
  logic             divisor_zero;
  logic [WIDTH:0]   trial;

  assign divisor_zero = (divisor == '0);
  assign accept       = (state_q == S_IDLE) && div_start;

  // Trial subtraction is one bit wider so its MSB acts as the borrow / restore flag.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_a_q    <= 1'b0;
      neg_quo_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      zero_div_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_a_q    <= neg_a_d;
      neg_quo_q  <= neg_quo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      zero_div_q <= zero_div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && !divisor_zero) state_d = S_CALC;
      S_CALC: if (cnt_q == LAST_STEP) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_a_d    = neg_a_q;
    neg_quo_d  = neg_quo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    zero_div_d = zero_div_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (divisor_zero) begin
            zero_div_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            // Magnitudes are taken as unsigned WIDTH-bit values, so the most-negative operand fits.
            zero_div_d = 1'b0;
            cnt_d      = '0;
            rem_d      = '0;
            quo_d      = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
            dvs_d      = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
            neg_a_d    = dividend[WIDTH-1];
            neg_quo_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
      S_FIX: begin
        lo_d   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        hi_d   = neg_a_q ? (~rem_q + 1'b1) : rem_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign zero_div = zero_div_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard testbench for div_unit against a signed-arithmetic reference
module tb_div_unit;

  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zd;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, zero_div;
  logic [31:0] hi, lo;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .div_start(div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .zero_div (zero_div),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Truncating signed division; remainder carries the dividend's sign.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa, sb_v;
    sa   = int'($signed(a));
    sb_v = int'($signed(b));
    e.due = 0;
    if (b == 0) begin
      e.hi = model_hi;
      e.lo = model_lo;
      e.zd = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.hi = 32'h0;
      e.lo = 32'h8000_0000;
      e.zd = 1'b0;
    end else begin
      e.lo = 32'(sa / sb_v);
      e.hi = 32'(sa % sb_v);
      e.zd = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation on the predicted cycle.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.due));
        check("lo", lo, e.lo);
        check("hi", hi, e.hi);
        check("zero_div", {31'd0, zero_div}, {31'd0, e.zd});
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    if (push) begin
      e = model(a, b);
      e.due = (b == 0) ? cyc + 1 : cyc + WIDTH + 2;
      sb.push_back(e);
      if (b != 0) begin
        model_hi = e.hi;
        model_lo = e.lo;
      end
    end
    div_start = 1'b1;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    @(negedge clk);
    if (push) begin
      check("busy_after_accept", {31'd0, busy}, {31'd0, (b != 0)});
      if (b != 0) check("zero_div_cleared", {31'd0, zero_div}, 32'd0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout_idle", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("timeout_done", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_zero_div", {31'd0, zero_div}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(32'd100, 32'd7, 1);
    wait_idle();
    issue(32'd5, 32'd0, 1);
    issue(32'd9, 32'd3, 1);
    wait_idle();

    issue(-32'sd100, 32'd7, 1);
    wait_idle();
    issue(32'd100, -32'sd7, 1);
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_idle();
    issue(32'h8000_0000, 32'd1, 1);
    wait_idle();

    // Start while busy must be ignored.
    issue(32'd1000, 32'd3, 1);
    repeat (8) @(negedge clk);
    issue(32'd8, 32'd2, 0);
    wait_idle();

    // Reset mid-operation.
    issue(32'd1000, 32'd3, 0);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_zero_div", {31'd0, zero_div}, 32'd0);
    model_hi = '0;
    model_lo = '0;
    reset = 1'b1;
    @(negedge clk);
    issue(32'd1000, 32'd3, 1);
    wait_idle();

    // Back-to-back: start in the done cycle.
    issue(32'd77, 32'd4, 1);
    wait_done();
    issue(32'd50, 32'd5, 1);
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = 32'd0; b = $urandom; end
        1: begin a = 32'($urandom_range(0, 50)) - 32'd25; b = 32'($urandom_range(100, 1000)); end
        2: begin a = $urandom; b = 32'd0; end
        3: begin a = $urandom; b = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFF_FFFF; end
        4: begin a = $urandom; b = 32'($urandom_range(1, 20)) - 32'd10; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      if ($urandom_range(0, 3) == 0) begin
        wait_done();
        issue(a, b, 1);
      end else begin
        issue(a, b, 1);
      end
      if (b != 0) wait_done();
    end
    wait_idle();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
